// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding, flag bundle and opcode validity helper for the pipelined ALU
package alu_pkg;

    typedef enum logic [3:0] {
        SEL       = 4'd0,
        INC       = 4'd1,
        DEC       = 4'd2,
        ADD       = 4'd3,
        ADD_c     = 4'd4,
        SUB       = 4'd5,
        SUB_b     = 4'd6,
        AND       = 4'd7,
        OR        = 4'd8,
        XOR       = 4'd9,
        SHIFT_L   = 4'd10,
        SHIFT_R   = 4'd11,
        ROTATE_L  = 4'd12,
        ROTATE_R  = 4'd13,
        invalid_1 = 4'd14,
        invalid_2 = 4'd15
    } opcode_e;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } alu_flags_t;

    function automatic logic is_valid_op(opcode_e op);
        return (op != invalid_1) && (op != invalid_2);
    endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle; master drives operands and consumes results
interface alu_pipe_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
);
    import alu_pkg::*;

    logic                 valid_in;
    logic                 ready_in;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cin;
    opcode_e              ctl;
    logic                 valid_out;
    logic                 ready_out;
    logic [WIDTH-1:0]     alu;
    logic                 carry;
    logic                 overflow;
    logic                 zero;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output valid_in, a, b, cin, ctl, ready_out,
        input  ready_in, valid_out, alu, carry, overflow, zero, err, err_cnt
    );

    modport slave (
        input  valid_in, a, b, cin, ctl, ready_out,
        output ready_in, valid_out, alu, carry, overflow, zero, err, err_cnt
    );

endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core: combinational ALU datapath producing result and carry/overflow/zero flags
module alu_pipe_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  opcode_e          ctl_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic           cin_add;
    logic           cin_sub;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign cin_add = (ctl_i == ADD_c) && cin_i;
    assign cin_sub = (ctl_i == SUB_b) && cin_i;
    assign sum     = {1'b0, a_i} + {1'b0, b_i} + (WIDTH+1)'(cin_add);
    assign diff    = {1'b0, a_i} - {1'b0, b_i} - (WIDTH+1)'(cin_sub);

    // opcode decode; bit WIDTH of the widened sum/difference is the carry/borrow
    always_comb begin
        result_o = '0;
        flags_o  = '0;
        case (ctl_i)
            SEL:      result_o = b_i;
            INC: begin
                result_o         = b_i + WIDTH'(1);
                flags_o.overflow = (b_i == MAX_POS);
            end
            DEC: begin
                result_o         = b_i - WIDTH'(1);
                flags_o.overflow = (b_i == MIN_NEG);
            end
            ADD, ADD_c: begin
                result_o         = sum[WIDTH-1:0];
                flags_o.carry    = sum[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            SUB, SUB_b: begin
                result_o         = diff[WIDTH-1:0];
                flags_o.carry    = diff[WIDTH];
                flags_o.overflow = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            AND:      result_o = a_i & b_i;
            OR:       result_o = a_i | b_i;
            XOR:      result_o = a_i ^ b_i;
            SHIFT_L:  result_o = a_i << 1;
            SHIFT_R:  result_o = a_i >> 1;
            ROTATE_L: result_o = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            ROTATE_R: result_o = {a_i[0], a_i[WIDTH-1:1]};
            default:  result_o = '0;
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline with invalid-opcode drop and saturating error count
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic     clk,
    input  logic     reset,
    alu_pipe_if.slave bus
);

    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_b_q;
    logic                 s1_cin_q;
    opcode_e              s1_ctl_q;
    logic                 valid_out_q, valid_out_d;
    logic [WIDTH-1:0]     alu_q;
    alu_flags_t           flags_q;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0]     core_result;
    alu_flags_t           core_flags;
    logic                 s1_en, s2_en, s1_ok;

    // S2 empties or is consumed this cycle; S1 may refill whenever S2 advances or S1 is empty
    assign s2_en       = !valid_out_q || bus.ready_out;
    assign s1_en       = !s1_valid_q || s2_en;
    assign s1_ok       = s1_valid_q && is_valid_op(s1_ctl_q);
    assign s1_valid_d  = s1_en ? bus.valid_in : s1_valid_q;
    assign valid_out_d = s2_en ? s1_ok : valid_out_q;
    assign err_d       = s2_en && s1_valid_q && !is_valid_op(s1_ctl_q);
    assign err_cnt_d   = (err_d && err_cnt_q != '1) ? err_cnt_q + ERR_CNT_W'(1) : err_cnt_q;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .a_i      (s1_a_q),
        .b_i      (s1_b_q),
        .cin_i    (s1_cin_q),
        .ctl_i    (s1_ctl_q),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    // S1: operand capture on every accepted input beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_cin_q   <= 1'b0;
            s1_ctl_q   <= SEL;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_en && bus.valid_in) begin
                s1_a_q   <= bus.a;
                s1_b_q   <= bus.b;
                s1_cin_q <= bus.cin;
                s1_ctl_q <= bus.ctl;
            end
        end
    end

    // S2: result register, error pulse and saturating error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_out_q <= 1'b0;
            alu_q       <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            valid_out_q <= valid_out_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
            if (s2_en && s1_ok) begin
                alu_q   <= core_result;
                flags_q <= core_flags;
            end
        end
    end

    assign bus.ready_in  = s1_en;
    assign bus.valid_out = valid_out_q;
    assign bus.alu       = alu_q;
    assign bus.carry     = flags_q.carry;
    assign bus.overflow  = flags_q.overflow;
    assign bus.zero      = flags_q.zero && valid_out_q;
    assign bus.err       = err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe against an arithmetic reference model
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int M  = 2 ** W;
    localparam int HM = 2 ** (W - 1);

    typedef struct {
        int alu;
        bit c;
        bit v;
        bit z;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   inv_sent = 0;
    int   err_seen = 0;
    int   outs = 0;
    int   run = 0;
    int   max_run = 0;
    bit   in_xfer = 0;
    bit   stall_prev = 0;
    logic [W-1:0] alu_prev;
    logic c_prev, v_prev;

    alu_pipe_if #(.WIDTH(W), .ERR_CNT_W(4)) bus ();

    alu_pipe #(.WIDTH(W), .ERR_CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int sgn(int x);
        return (x >= HM) ? x - M : x;
    endfunction

    function automatic exp_t model(int a, int b, int c, int op);
        exp_t e;
        int r;
        e.c = 0;
        e.v = 0;
        r   = 0;
        case (op)
            0:  r = b;
            1: begin r = b + 1; e.v = (sgn(b) + 1 > HM - 1); end
            2: begin r = b - 1; e.v = (sgn(b) - 1 < -HM); end
            3: begin r = a + b; e.c = (r >= M); e.v = (sgn(a) + sgn(b) > HM - 1) || (sgn(a) + sgn(b) < -HM); end
            4: begin r = a + b + c; e.c = (r >= M); e.v = (sgn(a) + sgn(b) + c > HM - 1) || (sgn(a) + sgn(b) + c < -HM); end
            5: begin r = a - b; e.c = (r < 0); e.v = (sgn(a) - sgn(b) > HM - 1) || (sgn(a) - sgn(b) < -HM); end
            6: begin r = a - b - c; e.c = (r < 0); e.v = (sgn(a) - sgn(b) - c > HM - 1) || (sgn(a) - sgn(b) - c < -HM); end
            7:  r = a & b;
            8:  r = a | b;
            9:  r = a ^ b;
            10: r = a * 2;
            11: r = a / 2;
            12: r = a * 2 + a / HM;
            13: r = a / 2 + (a % 2) * HM;
            default: r = 0;
        endcase
        e.alu = ((r % M) + M) % M;
        e.z   = (e.alu == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (stall_prev) begin
            chk("stall_alu", bus.alu, alu_prev);
            chk("stall_carry", bus.carry, c_prev);
            chk("stall_ovf", bus.overflow, v_prev);
        end
        stall_prev = bus.valid_out && !bus.ready_out;
        alu_prev   = bus.alu;
        c_prev     = bus.carry;
        v_prev     = bus.overflow;
        if (bus.err) err_seen++;
        run = bus.valid_out ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (bus.valid_out && bus.ready_out) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_output observed=%0h expected=none", bus.alu);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_alu", bus.alu, e.alu);
                chk("sb_carry", bus.carry, e.c);
                chk("sb_ovf", bus.overflow, e.v);
                chk("sb_zero", bus.zero, e.z);
                outs++;
            end
        end
        in_xfer = bus.valid_in && bus.ready_in;
        if (in_xfer) begin
            if (int'(bus.ctl) < 14) exp_q.push_back(model(int'(bus.a), int'(bus.b), int'(bus.cin), int'(bus.ctl)));
            else inv_sent++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input int c, input int op);
        bus.valid_in = 1'b1;
        bus.a        = W'(a);
        bus.b        = W'(b);
        bus.cin      = c[0];
        bus.ctl      = opcode_e'(op);
    endtask

    task automatic send(input int a, input int b, input int c, input int op);
        int guard = 0;
        drive(a, b, c, op);
        do begin
            tick();
            guard++;
        end while (!in_xfer && guard < 50);
        total++;
        assert (in_xfer) else begin
            bad++;
            $error("FAIL send_timeout observed=%0d expected=1", in_xfer);
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.ctl       = SEL;
        reset         = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_valid_out", bus.valid_out, 0);
        chk("rst_alu", bus.alu, 0);
        chk("rst_carry", bus.carry, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_ready_in", bus.ready_in, 1);

        send(8'hF0, 8'h20, 0, 3);
        chk("lat_c1_valid", bus.valid_out, 0);
        tick();
        chk("lat_c2_valid", bus.valid_out, 1);
        chk("add_alu", bus.alu, 8'h10);
        chk("add_carry", bus.carry, 1);
        chk("add_ovf", bus.overflow, 0);
        chk("add_zero", bus.zero, 0);
        drain(4);

        send(8'h7F, 8'h01, 0, 3);
        drain(4);
        chk("add_ovf_alu", bus.alu, 8'h80);
        chk("add_ovf_ovf", bus.overflow, 1);
        chk("add_ovf_carry", bus.carry, 0);
        send(8'h00, 8'h00, 1, 6);
        drain(4);
        chk("subb_alu", bus.alu, 8'hFF);
        chk("subb_carry", bus.carry, 1);
        chk("subb_ovf", bus.overflow, 0);

        max_run = 0;
        outs    = 0;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 0, 9);
        drain(5);
        chk("stream_outs", outs, 8);
        chk("stream_run", max_run, 8);

        outs          = 0;
        bus.ready_out = 1'b0;
        drive(8'h11, 8'h22, 0, 3);
        tick();
        chk("stall_acc1", in_xfer, 1);
        drive(8'h33, 8'h44, 0, 5);
        tick();
        chk("stall_acc2", in_xfer, 1);
        chk("stall_ready_in", bus.ready_in, 0);
        chk("stall_valid_out", bus.valid_out, 1);
        drive(8'h0F, 8'h0F, 0, 8);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_accept", in_xfer, 0);
        end
        bus.ready_out = 1'b1;
        #1;
        chk("release_ready_in", bus.ready_in, 1);
        tick();
        chk("release_accept", in_xfer, 1);
        drain(5);
        chk("stall_outs", outs, 3);
        chk("stall_empty", exp_q.size(), 0);

        outs     = 0;
        err_seen = 0;
        inv_sent = 0;
        send(0, 0, 0, 14);
        send(0, 8'h00, 0, 0);
        drain(5);
        chk("inv_err_pulses", err_seen, 1);
        chk("inv_err_cnt", bus.err_cnt, 1);
        chk("inv_outs", outs, 1);
        chk("inv_alu", bus.alu, 0);
        for (int i = 0; i < 20; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 0, 14 + (i % 2));
        drain(5);
        chk("sat_err_cnt", bus.err_cnt, 4'hF);
        chk("sat_err_pulses", err_seen, 21);

        for (int i = 0; i < 300; i++) begin
            bus.valid_in  = ($urandom_range(0, 3) != 0);
            bus.a         = W'($urandom_range(0, 255));
            bus.b         = W'($urandom_range(0, 255));
            bus.cin       = 1'($urandom_range(0, 1));
            bus.ctl       = opcode_e'($urandom_range(0, 15));
            bus.ready_out = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain(6);
        chk("rand_empty", exp_q.size(), 0);
        chk("rand_err_pulses", err_seen, inv_sent);
        chk("rand_err_cnt", bus.err_cnt, (inv_sent > 15) ? 15 : inv_sent);

        send(8'h01, 8'h02, 0, 3);
        send(8'h03, 8'h04, 0, 3);
        chk("inflight_valid", bus.valid_out, 1);
        reset = 1'b0;
        #1;
        chk("async_valid_out", bus.valid_out, 0);
        chk("async_alu", bus.alu, 0);
        chk("async_err_cnt", bus.err_cnt, 0);
        exp_q.delete();
        stall_prev = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        outs = 0;
        drain(4);
        chk("no_stale_outs", outs, 0);
        send(8'h01, 8'h00, 0, 13);
        drain(4);
        chk("post_rst_outs", outs, 1);
        chk("rotr_alu", bus.alu, 8'h80);
        chk("rotr_carry", bus.carry, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
